path_replayer: RTL and testbench
================================

# path_replayer

Downstream consumer of the location stack once it has switched to queue (replay) mode. Pops the solved path from first to last cell, converts each pair of consecutive 8-bit locations ({x[3:0], y[3:0]}) into a 2-bit move direction, and hands the moves to the movement/display stage over a valid/ready handshake. Counts emitted steps and flags any non-adjacent pair as a path error.

## Interface
Parameters:
- LOC_W, 8, location width; x = loc[7:4], y = loc[3:0]
- CNT_W, 8, step counter width

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle pulse: begin replay (issued after the stack's done)
- empty_i  in  1  stack reports no entries left to pop
- loc_i  in  LOC_W  location presented by the stack, valid the cycle after pop_o
- pop_o  out  1  one-cycle pop request to the stack
- run_o  out  1  held high for the whole replay (enables queue-mode pop)
- dir_o  out  2  move direction: 00 UP (y-1), 01 RIGHT (x+1), 10 DOWN (y+1), 11 LEFT (x-1)
- dir_valid_o  out  1  dir_o holds a valid move
- dir_ready_i  in  1  downstream accepts the move
- step_cnt_o  out  CNT_W  number of moves accepted since start
- busy_o  out  1  replay in progress
- finish_o  out  1  level, replay completed cleanly
- err_o  out  1  level, sticky, non-adjacent pair found

## Operation
- States: IDLE, FETCH, CAPT, EMIT, DONE, ERR.
- IDLE: all outputs low. start_i -> FETCH; clear step_cnt, finish, err, first flag set.
- FETCH: run_o=1. If empty_i -> DONE. Else pop_o=1 for exactly this cycle -> CAPT.
- CAPT: register loc_i as cur. If first flag: prev<=cur, clear first, -> FETCH (no move for the start cell). Else decode (prev, cur):
  - dx=+1, dy=0 -> RIGHT; dx=-1 -> LEFT; dy=+1 -> DOWN; dy=-1 -> UP.
  - Differences computed on 5-bit signed values; no wrap (x 15->0 is illegal). Same cell, diagonal, or |d|>1 -> ERR.
  - Legal -> EMIT with dir_o registered.
- EMIT: dir_valid_o=1, dir_o stable until dir_ready_i. On valid&ready: step_cnt+1 (saturates at 2^CNT_W-1), prev<=cur, -> FETCH.
- DONE: finish_o=1, run_o=0, busy_o=0. start_i -> restart as from IDLE.
- ERR: err_o=1, run_o=0, no further pops. start_i -> restart (err cleared).
- start_i in FETCH/CAPT/EMIT ignored.
- empty at first FETCH -> DONE, step_cnt 0. Single-entry path -> DONE, step_cnt 0.

## Timing
- Reset values: pop_o 0, run_o 0, dir_o 00, dir_valid_o 0, step_cnt_o 0, busy_o 0, finish_o 0, err_o 0; state IDLE.
- rst has priority over every input, including mid-EMIT; next edge returns to IDLE, no pop issued.
- start_i at edge N -> FETCH at N+1; pop_o high during cycle N+1; loc_i sampled at edge N+2.
- Per move, minimum 3 cycles (FETCH, CAPT, EMIT with ready already high); start cell costs 2 cycles.
- dir_valid_o never drops without a handshake; dir_o must not change while valid&!ready.
- pop_o never asserted in two consecutive cycles nor while empty_i=1.
- busy_o high in FETCH, CAPT, EMIT.

## Structure
- Shared package maze_pkg: LOC_W, coordinate slice helpers, DIR_UP/DIR_RIGHT/DIR_DOWN/DIR_LEFT constants, replay state encoding.
- One sub-module: step_decoder (combinational; prev, cur -> dir, legal).
- Top holds FSM, prev/cur registers, step counter.

## Test plan
- Path 0x00,0x10,0x11,0x21, ready always 1 -> dirs RIGHT, DOWN, RIGHT; step_cnt 3; finish_o 1; exactly 4 pops.
- Same path, dir_ready_i low 5 cycles on 2nd move -> dir_o held DOWN, valid stays high, no extra pop, final step_cnt 3.
- Path 0x00,0x11 (diagonal) -> err_o 1, no dir_valid_o, run_o 0, one pop after the error pair only (2 pops total); then start_i with legal path clears err_o.
- Empty stack at start -> DONE after 1 FETCH cycle, no pop, step_cnt 0; single entry 0x55 -> 1 pop, step_cnt 0, finish_o 1.
- Wrap check 0xF0 -> 0x00 -> err_o 1; 0x0F -> 0x00 -> UP... (dy=-15) err_o 1.
- rst asserted during EMIT -> next cycle all outputs at reset values, state IDLE; start_i pulse mid-replay has no effect.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared maze definitions: location geometry, move direction codes and the
// replay FSM state encoding used by the path replayer.
package maze_pkg;

  localparam int LOC_W = 8;
  localparam int CNT_W = 8;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPT,
    ST_EMIT,
    ST_DONE,
    ST_ERR
  } replay_state_e;

  function automatic logic [3:0] loc_x(input logic [LOC_W-1:0] loc);
    return loc[7:4];
  endfunction

  function automatic logic [3:0] loc_y(input logic [LOC_W-1:0] loc);
    return loc[3:0];
  endfunction

endpackage

// File: rtl/step_decoder.sv
// Turns a pair of consecutive path cells into a move direction and flags
// whether the pair is a legal single orthogonal step (no edge wrap).
module step_decoder
  import maze_pkg::*;
(
  input  logic [LOC_W-1:0] prev_i,
  input  logic [LOC_W-1:0] cur_i,
  output logic [1:0]       dir_o,
  output logic             legal_o
);

  logic signed [4:0] dx;
  logic signed [4:0] dy;

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    dx      = $signed({1'b0, loc_x(cur_i)}) - $signed({1'b0, loc_x(prev_i)});
    dy      = $signed({1'b0, loc_y(cur_i)}) - $signed({1'b0, loc_y(prev_i)});
    dir_o   = DIR_UP;
    legal_o = 1'b0;
    if (dy == 5'sd0) begin
      if (dx == 5'sd1) begin
        dir_o   = DIR_RIGHT;
        legal_o = 1'b1;
      end else if (dx == -5'sd1) begin
        dir_o   = DIR_LEFT;
        legal_o = 1'b1;
      end
    end else if (dx == 5'sd0) begin
      if (dy == 5'sd1) begin
        dir_o   = DIR_DOWN;
        legal_o = 1'b1;
      end else if (dy == -5'sd1) begin
        dir_o   = DIR_UP;
        legal_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/path_replayer.sv
// Replays a solved maze path from the location stack, emitting one move per
// adjacent cell pair over valid/ready, counting steps and flagging bad pairs.
module path_replayer #(
  parameter int LOC_W = maze_pkg::LOC_W,
  parameter int CNT_W = maze_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             empty_i,
  input  logic [LOC_W-1:0] loc_i,
  output logic             pop_o,
  output logic             run_o,
  output logic [1:0]       dir_o,
  output logic             dir_valid_o,
  input  logic             dir_ready_i,
  output logic [CNT_W-1:0] step_cnt_o,
  output logic             busy_o,
  output logic             finish_o,
  output logic             err_o
);

  maze_pkg::replay_state_e state_q, state_d;
  logic [LOC_W-1:0] prev_q, prev_d;
  logic [LOC_W-1:0] cur_q, cur_d;
  logic [1:0]       dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;

  logic [1:0] dec_dir;
  logic       dec_legal;

  step_decoder u_step_decoder (
    .prev_i  (prev_q),
    .cur_i   (loc_i),
    .dir_o   (dec_dir),
    .legal_o (dec_legal)
  );

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    case (state_q)
      maze_pkg::ST_IDLE, maze_pkg::ST_DONE, maze_pkg::ST_ERR: begin
        if (start_i) begin
          state_d = maze_pkg::ST_FETCH;
          cnt_d   = '0;
          first_d = 1'b1;
        end
      end
      maze_pkg::ST_FETCH: begin
        state_d = empty_i ? maze_pkg::ST_DONE : maze_pkg::ST_CAPT;
      end
      maze_pkg::ST_CAPT: begin
        cur_d = loc_i;
        if (first_q) begin
          // The start cell only seeds prev; it produces no move.
          prev_d  = loc_i;
          first_d = 1'b0;
          state_d = maze_pkg::ST_FETCH;
        end else if (dec_legal) begin
          dir_d   = dec_dir;
          state_d = maze_pkg::ST_EMIT;
        end else begin
          state_d = maze_pkg::ST_ERR;
        end
      end
      maze_pkg::ST_EMIT: begin
        if (dir_ready_i) begin
          cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
          prev_d  = cur_q;
          state_d = maze_pkg::ST_FETCH;
        end
      end
      default: state_d = maze_pkg::ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= maze_pkg::ST_IDLE;
      prev_q  <= '0;
      cur_q   <= '0;
      dir_q   <= maze_pkg::DIR_UP;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // Pop looks at empty_i in the same cycle so an empty stack is never popped.
  assign pop_o       = (state_q == maze_pkg::ST_FETCH) && !empty_i;
  assign busy_o      = (state_q == maze_pkg::ST_FETCH) || (state_q == maze_pkg::ST_CAPT) ||
                       (state_q == maze_pkg::ST_EMIT);
  assign run_o       = busy_o;
  assign dir_valid_o = (state_q == maze_pkg::ST_EMIT);
  assign dir_o       = dir_q;
  assign step_cnt_o  = cnt_q;
  assign finish_o    = (state_q == maze_pkg::ST_DONE);
  assign err_o       = (state_q == maze_pkg::ST_ERR);

endmodule

// File: tb/tb_path_replayer.sv
// Directed bench for path_replayer: a queue models the location stack and
// each scenario task checks moves, counts, pops and flags against hand values.
module tb_path_replayer;
  import maze_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic       empty_i = 1'b1;
  logic [7:0] loc_i = 8'h00;
  logic       pop_o;
  logic       run_o;
  logic [1:0] dir_o;
  logic       dir_valid_o;
  logic       dir_ready_i = 1'b1;
  logic [7:0] step_cnt_o;
  logic       busy_o;
  logic       finish_o;
  logic       err_o;

  path_replayer dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .empty_i     (empty_i),
    .loc_i       (loc_i),
    .pop_o       (pop_o),
    .run_o       (run_o),
    .dir_o       (dir_o),
    .dir_valid_o (dir_valid_o),
    .dir_ready_i (dir_ready_i),
    .step_cnt_o  (step_cnt_o),
    .busy_o      (busy_o),
    .finish_o    (finish_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] stack_q[$];
  logic [1:0] got_q[$];
  int pops = 0;
  int pop_viol = 0;
  int stab_viol = 0;
  int stall_bad = 0;
  int stalled_cycles = 0;
  int run_cycles = 0;
  bit prev_pop = 0;

  // Stack model: a pop seen in cycle N presents the next entry just after edge N+1.
  initial begin
    forever begin
      @(negedge clk);
      if (pop_o) begin
        pops++;
        if (empty_i) pop_viol++;
        if (prev_pop) pop_viol++;
        prev_pop = 1;
        @(posedge clk);
        #1;
        if (stack_q.size() > 0) loc_i = stack_q.pop_front();
        empty_i = (stack_q.size() == 0);
      end else begin
        prev_pop = 0;
      end
    end
  end

  task automatic load_path(input logic [7:0] p[$]);
    stack_q = p;
    empty_i = (stack_q.size() == 0);
  endtask

  task automatic run_replay(input int stall_move, input int stall_len, input int max_cyc,
                            output bit timed_out);
    int  cyc = 0;
    bit  pv = 0;
    bit  pr = 0;
    logic [1:0] pd = 2'b00;
    got_q.delete();
    pops = 0; pop_viol = 0; stab_viol = 0; stall_bad = 0; stalled_cycles = 0;
    dir_ready_i = 1'b1;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    timed_out = 1;
    while (cyc < max_cyc) begin
      if (finish_o || err_o) begin
        timed_out = 0;
        break;
      end
      if (pv && !pr && (!dir_valid_o || dir_o !== pd)) stab_viol++;
      if (dir_valid_o && got_q.size() == stall_move && stalled_cycles < stall_len) begin
        dir_ready_i = 1'b0;
        stalled_cycles++;
        if (dir_o !== DIR_DOWN) stall_bad++;
      end else begin
        dir_ready_i = 1'b1;
      end
      if (dir_valid_o && dir_ready_i) got_q.push_back(dir_o);
      pv = dir_valid_o; pr = dir_ready_i; pd = dir_o;
      cyc++;
      @(negedge clk);
    end
    run_cycles = cyc;
    dir_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if ({pop_o, run_o, dir_o, dir_valid_o, step_cnt_o, busy_o, finish_o, err_o} !== 15'h0)
      $display("FAIL reset_outputs: got %h expected 0", {pop_o, run_o, dir_o, dir_valid_o, step_cnt_o, busy_o, finish_o, err_o});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (busy_o !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy_o); else n_pass++;
  endtask

  task automatic test_basic();
    bit to;
    logic [1:0] exp_d[3] = '{DIR_RIGHT, DIR_DOWN, DIR_RIGHT};
    load_path('{8'h00, 8'h10, 8'h11, 8'h21});
    run_replay(-1, 0, 100, to);
    n_chk++; if (to) $display("FAIL basic_timeout: got timeout expected finish"); else n_pass++;
    n_chk++; if (got_q.size() != 3) $display("FAIL basic_moves: got %0d expected 3", got_q.size()); else n_pass++;
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_d[i]) $display("FAIL basic_dir%0d: got %b expected %b", i, got_q[i], exp_d[i]); else n_pass++;
    end
    n_chk++; if (step_cnt_o !== 8'd3) $display("FAIL basic_cnt: got %0d expected 3", step_cnt_o); else n_pass++;
    n_chk++; if (finish_o !== 1'b1 || err_o !== 1'b0) $display("FAIL basic_flags: got fin=%b err=%b expected fin=1 err=0", finish_o, err_o); else n_pass++;
    n_chk++; if (pops != 4) $display("FAIL basic_pops: got %0d expected 4", pops); else n_pass++;
    n_chk++; if (run_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL basic_done_run: got run=%b busy=%b expected 0", run_o, busy_o); else n_pass++;
    n_chk++; if (pop_viol != 0) $display("FAIL basic_pop_rules: got %0d violations expected 0", pop_viol); else n_pass++;
    // 2 (start cell) + 3*3 (moves) + 1 final fetch
    n_chk++; if (run_cycles != 12) $display("FAIL basic_latency: got %0d cycles expected 12", run_cycles); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit to;
    load_path('{8'h00, 8'h10, 8'h11, 8'h21});
    run_replay(1, 5, 100, to);
    n_chk++; if (to) $display("FAIL bp_timeout: got timeout expected finish"); else n_pass++;
    n_chk++; if (stalled_cycles != 5) $display("FAIL bp_stall_len: got %0d expected 5", stalled_cycles); else n_pass++;
    n_chk++; if (stall_bad != 0) $display("FAIL bp_dir_held: got %0d bad cycles expected 0", stall_bad); else n_pass++;
    n_chk++; if (stab_viol != 0) $display("FAIL bp_valid_stable: got %0d drops expected 0", stab_viol); else n_pass++;
    n_chk++; if (got_q.size() != 3 || got_q[1] !== DIR_DOWN) $display("FAIL bp_moves: got %0d moves expected 3 with DOWN second", got_q.size()); else n_pass++;
    n_chk++; if (pops != 4) $display("FAIL bp_pops: got %0d expected 4", pops); else n_pass++;
    n_chk++; if (step_cnt_o !== 8'd3) $display("FAIL bp_cnt: got %0d expected 3", step_cnt_o); else n_pass++;
  endtask

  task automatic test_up_left();
    bit to;
    load_path('{8'h11, 8'h10, 8'h00});
    run_replay(-1, 0, 100, to);
    n_chk++; if (to || got_q.size() != 2) $display("FAIL ul_moves: got %0d moves (to=%b) expected 2", got_q.size(), to);
    else begin
      n_pass++;
      n_chk++; if (got_q[0] !== DIR_UP) $display("FAIL ul_up: got %b expected %b", got_q[0], DIR_UP); else n_pass++;
      n_chk++; if (got_q[1] !== DIR_LEFT) $display("FAIL ul_left: got %b expected %b", got_q[1], DIR_LEFT); else n_pass++;
    end
    n_chk++; if (step_cnt_o !== 8'd2) $display("FAIL ul_cnt: got %0d expected 2", step_cnt_o); else n_pass++;
  endtask

  task automatic test_error();
    bit to;
    load_path('{8'h00, 8'h11});
    run_replay(-1, 0, 100, to);
    n_chk++; if (to || err_o !== 1'b1) $display("FAIL diag_err: got err=%b (to=%b) expected 1", err_o, to); else n_pass++;
    n_chk++; if (got_q.size() != 0) $display("FAIL diag_no_move: got %0d moves expected 0", got_q.size()); else n_pass++;
    n_chk++; if (pops != 2) $display("FAIL diag_pops: got %0d expected 2", pops); else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++; if (run_o !== 1'b0 || finish_o !== 1'b0 || err_o !== 1'b1 || pops != 2)
      $display("FAIL diag_hold: got run=%b fin=%b err=%b pops=%0d expected 0 0 1 2", run_o, finish_o, err_o, pops);
    else n_pass++;
    load_path('{8'h00, 8'h01});
    run_replay(-1, 0, 100, to);
    n_chk++; if (to || err_o !== 1'b0 || finish_o !== 1'b1) $display("FAIL err_clear: got err=%b fin=%b expected 0 1", err_o, finish_o); else n_pass++;
    n_chk++; if (got_q.size() != 1 || got_q[0] !== DIR_DOWN || step_cnt_o !== 8'd1)
      $display("FAIL err_clear_move: got %0d moves cnt=%0d expected 1 DOWN cnt=1", got_q.size(), step_cnt_o);
    else n_pass++;
  endtask

  task automatic test_empty_single();
    bit to;
    load_path('{});
    run_replay(-1, 0, 100, to);
    n_chk++; if (to || finish_o !== 1'b1) $display("FAIL empty_finish: got fin=%b expected 1", finish_o); else n_pass++;
    n_chk++; if (run_cycles != 1) $display("FAIL empty_fetch_cycles: got %0d expected 1", run_cycles); else n_pass++;
    n_chk++; if (pops != 0 || step_cnt_o !== 8'd0) $display("FAIL empty_pops: got pops=%0d cnt=%0d expected 0 0", pops, step_cnt_o); else n_pass++;
    load_path('{8'h55});
    run_replay(-1, 0, 100, to);
    n_chk++; if (to || finish_o !== 1'b1 || err_o !== 1'b0) $display("FAIL single_finish: got fin=%b err=%b expected 1 0", finish_o, err_o); else n_pass++;
    n_chk++; if (pops != 1 || step_cnt_o !== 8'd0) $display("FAIL single_pops: got pops=%0d cnt=%0d expected 1 0", pops, step_cnt_o); else n_pass++;
  endtask

  task automatic test_wrap();
    bit to;
    load_path('{8'hF0, 8'h00});
    run_replay(-1, 0, 100, to);
    n_chk++; if (to || err_o !== 1'b1 || got_q.size() != 0) $display("FAIL wrap_x: got err=%b moves=%0d expected 1 0", err_o, got_q.size()); else n_pass++;
    load_path('{8'h0F, 8'h00});
    run_replay(-1, 0, 100, to);
    n_chk++; if (to || err_o !== 1'b1 || got_q.size() != 0) $display("FAIL wrap_y: got err=%b moves=%0d expected 1 0", err_o, got_q.size()); else n_pass++;
    load_path('{8'h33, 8'h33});
    run_replay(-1, 0, 100, to);
    n_chk++; if (to || err_o !== 1'b1) $display("FAIL same_cell: got err=%b expected 1", err_o); else n_pass++;
  endtask

  task automatic test_rst_mid_emit();
    int w = 0;
    load_path('{8'h00, 8'h10});
    pops = 0;
    dir_ready_i = 1'b0;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    while (!dir_valid_o && w < 20) begin
      w++;
      @(negedge clk);
    end
    n_chk++; if (!dir_valid_o || dir_o !== DIR_RIGHT) $display("FAIL rst_reach_emit: got valid=%b dir=%b expected 1 %b", dir_valid_o, dir_o, DIR_RIGHT); else n_pass++;
    start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (!dir_valid_o || pops != 2 || step_cnt_o !== 8'd0)
      $display("FAIL start_ignored: got valid=%b pops=%0d cnt=%0d expected 1 2 0", dir_valid_o, pops, step_cnt_o);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if ({pop_o, run_o, dir_o, dir_valid_o, step_cnt_o, busy_o, finish_o, err_o} !== 15'h0)
      $display("FAIL rst_emit_outputs: got %h expected 0", {pop_o, run_o, dir_o, dir_valid_o, step_cnt_o, busy_o, finish_o, err_o});
    else n_pass++;
    rst = 1'b0;
    dir_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (pops != 2 || busy_o !== 1'b0) $display("FAIL rst_idle_after: got pops=%0d busy=%b expected 2 0", pops, busy_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_up_left();
    test_error();
    test_empty_single();
    test_wrap();
    test_rst_mid_emit();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
